des_round_sequencer: RTL and testbench
======================================

# des_round_sequencer

Controller that sequences the DES round datapath (initial permutation load, expansion, key mixing, S-box substitution, P-permutation, L/R update, final permutation) through all 16 rounds of one 64-bit block. It drives the per-stage Select lines, waits on each stage's Finish flag, tracks the round count, and selects the subkey index for encrypt or decrypt. It sits between the top-level block interface (start/done) and the stage modules, including the expansion function.

## Interface
- STAGE_TIMEOUT, 15: maximum cycles a stage state waits for its Finish flag before error (1..255).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  request one block operation; sampled in IDLE only.
- Decrypt  input  1  mode, latched when Start is accepted: 0 = encrypt, 1 = decrypt.
- Busy  output  1  high from Start acceptance until DONE/ERROR exits.
- Done  output  1  one-cycle pulse: block complete.
- Error  output  1  sticky stage-timeout flag.
- Round  output  4  current round, 0..15.
- Subkey_Index  output  4  encrypt: Round; decrypt: 15 − Round.
- Load_Strobe  output  1  one-cycle pulse: datapath loads IP(input) into L/R.
- Expansion_Select / Key_Select / Sbox_Select / Perm_Select  output  1 each  stage enables.
- Expansion_Finish / Key_Finish / Sbox_Finish / Perm_Finish  input  1 each  stage completion flags.
- Round_Update  output  1  one-cycle pulse: L ← R, R ← L ⊕ f.
- Swap_Skip  output  1  high with Round_Update in round 15: datapath omits the L/R swap.
- Final_Strobe  output  1  one-cycle pulse: datapath applies inverse IP and registers the output.

## Operation
- States: IDLE, LOAD, EXPAND, KEYMIX, SBOX, PERM, UPDATE, FINAL, DONE, ERROR.
- All outputs are Moore-decoded from registered state, counters and latched mode.
- IDLE: Busy=0. If Start=1, latch Decrypt, clear Round and Error, go to LOAD.
- LOAD: Load_Strobe=1 for one cycle, then go to EXPAND.
- EXPAND, KEYMIX, SBOX and PERM each assert only their own Select. Each state advances to the next in that order on the first cycle its Finish flag is sampled high. Select drops in the cycle after the flag is seen.
- Finish flags from other stages are ignored.
- UPDATE: Round_Update=1 for one cycle; Swap_Skip=(Round==15).
  - If Round<15: Round increments and state goes to EXPAND.
  - Otherwise state goes to FINAL.
- FINAL: Final_Strobe=1 for one cycle, then go to DONE.
- DONE: Done=1 for one cycle, then go to IDLE. Busy is still 1 in DONE.
- Timeout: a wait counter clears on entry to each stage state and increments each cycle there. If it reaches STAGE_TIMEOUT without a Finish flag, go to ERROR.
- ERROR: Error=1, all Selects low. Go to IDLE the next cycle.
  - Error stays 1 until the next accepted Start or rst.
  - Done is not pulsed on error.
- Start while Busy=1 is ignored. A Decrypt change mid-block has no effect.

## Timing
- Reset values: state IDLE, Round=0, Subkey_Index=0, Error=0. All strobes, Selects, Busy and Done are 0.
- rst mid-operation forces IDLE on the next edge and aborts the block without Done.
- Stage with single-cycle-latency module (flag registered one cycle after Select): 2 cycles per stage.
- Round with all stages at minimum latency: 4×2 + 1 (UPDATE) = 9 cycles.
- Block latency at minimum: Start accepted at edge 0, LOAD in cycle 1, FINAL in cycle 146, Done in cycle 147. Busy is high for cycles 1–147.
- A Finish flag that is already high on entry to a stage state advances the state after one cycle.
- Timeout: ERROR is entered STAGE_TIMEOUT cycles after stage entry. Round holds the round in which the timeout occurred.
- Back-to-back blocks: Start held high is accepted in the IDLE cycle after DONE, giving 1 idle cycle between blocks.
- Round wraps only via IDLE; it never increments past 15.

## Test plan
- Encrypt, stages ack after 1 cycle, Start pulse → Load_Strobe in cycle 1, 16 Round_Update pulses, Subkey_Index 0..15, Swap_Skip only on the 16th, Done in cycle 147.
- Decrypt, same stimulus → Subkey_Index runs 15..0; cycle timing is identical to encrypt.
- Sbox_Finish delayed 5 cycles in round 7 → SBOX occupies 6 cycles, Done slips by 4 cycles to 151, no Error.
- Perm_Finish never asserted in round 3, STAGE_TIMEOUT=15 → ERROR 15 cycles after PERM entry, Round=3, Error=1, no Done. Next Start → Error clears.
- Start asserted during round 10 and rst asserted during round 12 → mid-block Start ignored; on rst, next cycle all outputs are at reset values and no Done occurs.
- Start held high continuously → consecutive blocks with Done pulses 148 cycles apart.

Source files
------------

// File: rtl/des_round_sequencer.sv
// Control FSM that walks the DES round datapath through load, 16 rounds of
// expand/keymix/sbox/perm/update, and the final permutation for one block.
module des_round_sequencer #(
  parameter int STAGE_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  input  logic       Decrypt,
  input  logic       Expansion_Finish,
  input  logic       Key_Finish,
  input  logic       Sbox_Finish,
  input  logic       Perm_Finish,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [3:0] Round,
  output logic [3:0] Subkey_Index,
  output logic       Load_Strobe,
  output logic       Expansion_Select,
  output logic       Key_Select,
  output logic       Sbox_Select,
  output logic       Perm_Select,
  output logic       Round_Update,
  output logic       Swap_Skip,
  output logic       Final_Strobe
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_EXPAND = 4'd2;
  localparam logic [3:0] S_KEYMIX = 4'd3;
  localparam logic [3:0] S_SBOX   = 4'd4;
  localparam logic [3:0] S_PERM   = 4'd5;
  localparam logic [3:0] S_UPDATE = 4'd6;
  localparam logic [3:0] S_FINAL  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;
  localparam logic [3:0] S_ERROR  = 4'd9;

  // Last wait count still inside the window; one more miss means timeout.
  localparam logic [7:0] WAIT_LAST = 8'(STAGE_TIMEOUT - 1);

  logic [3:0] r_state;
  logic [3:0] r_round;
  logic [7:0] r_wait;
  logic       r_decrypt;
  logic       r_error;

  logic       w_in_stage;
  logic       w_finish;
  logic [3:0] w_stage_next;

  // Only the flag belonging to the current stage is looked at.
  always_comb begin
    w_in_stage   = 1'b1;
    w_finish     = 1'b0;
    w_stage_next = S_IDLE;
    case (r_state)
      S_EXPAND: begin w_finish = Expansion_Finish; w_stage_next = S_KEYMIX; end
      S_KEYMIX: begin w_finish = Key_Finish;       w_stage_next = S_SBOX;   end
      S_SBOX:   begin w_finish = Sbox_Finish;      w_stage_next = S_PERM;   end
      S_PERM:   begin w_finish = Perm_Finish;      w_stage_next = S_UPDATE; end
      default:  w_in_stage = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_round   <= 4'd0;
      r_wait    <= 8'd0;
      r_decrypt <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_decrypt <= Decrypt;
            r_round   <= 4'd0;
            r_error   <= 1'b0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_wait  <= 8'd0;
          r_state <= S_EXPAND;
        end
        S_UPDATE: begin
          if (r_round == 4'd15) begin
            r_state <= S_FINAL;
          end else begin
            r_round <= r_round + 4'd1;
            r_wait  <= 8'd0;
            r_state <= S_EXPAND;
          end
        end
        S_FINAL: r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        S_ERROR: r_state <= S_IDLE;
        default: begin
          if (w_in_stage) begin
            if (w_finish) begin
              r_wait  <= 8'd0;
              r_state <= w_stage_next;
            end else if (r_wait == WAIT_LAST) begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end else begin
              r_wait <= r_wait + 8'd1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign Busy             = (r_state != S_IDLE);
  assign Done             = (r_state == S_DONE);
  assign Error            = r_error;
  assign Round            = r_round;
  assign Subkey_Index     = r_decrypt ? (4'd15 - r_round) : r_round;
  assign Load_Strobe      = (r_state == S_LOAD);
  assign Expansion_Select = (r_state == S_EXPAND);
  assign Key_Select       = (r_state == S_KEYMIX);
  assign Sbox_Select      = (r_state == S_SBOX);
  assign Perm_Select      = (r_state == S_PERM);
  assign Round_Update     = (r_state == S_UPDATE);
  assign Swap_Skip        = (r_state == S_UPDATE) && (r_round == 4'd15);
  assign Final_Strobe     = (r_state == S_FINAL);

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer: stage responders with per-round
// latency control and hand-computed cycle numbers for each block scenario.
module tb_des_round_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       Start, Decrypt;
  logic       Expansion_Finish, Key_Finish, Sbox_Finish, Perm_Finish;
  logic       Busy, Done, Error;
  logic [3:0] Round, Subkey_Index;
  logic       Load_Strobe, Expansion_Select, Key_Select, Sbox_Select, Perm_Select;
  logic       Round_Update, Swap_Skip, Final_Strobe;

  des_round_sequencer #(.STAGE_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Decrypt(Decrypt),
    .Expansion_Finish(Expansion_Finish), .Key_Finish(Key_Finish),
    .Sbox_Finish(Sbox_Finish), .Perm_Finish(Perm_Finish),
    .Busy(Busy), .Done(Done), .Error(Error), .Round(Round),
    .Subkey_Index(Subkey_Index), .Load_Strobe(Load_Strobe),
    .Expansion_Select(Expansion_Select), .Key_Select(Key_Select),
    .Sbox_Select(Sbox_Select), .Perm_Select(Perm_Select),
    .Round_Update(Round_Update), .Swap_Skip(Swap_Skip),
    .Final_Strobe(Final_Strobe)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Stage responders: Finish is registered lat cycles after Select rises.
  int sbox_slow_round = -1;
  int perm_hang_round = -1;
  int cnt [4];
  logic [3:0] fin_nxt;

  initial begin
    {Perm_Finish, Sbox_Finish, Key_Finish, Expansion_Finish} = 4'b0;
    for (int s = 0; s < 4; s++) cnt[s] = 0;
    forever begin
      logic [3:0] sel;
      @(negedge clk);
      sel = {Perm_Select, Sbox_Select, Key_Select, Expansion_Select};
      for (int s = 0; s < 4; s++) begin
        int lat;
        lat = 1;
        if (s == 2 && int'(Round) == sbox_slow_round) lat = 5;
        if (s == 3 && int'(Round) == perm_hang_round) lat = 1000;
        fin_nxt[s] = sel[s] && (cnt[s] + 1 >= lat);
        cnt[s] = sel[s] ? cnt[s] + 1 : 0;
      end
      @(posedge clk);
      #1;
      {Perm_Finish, Sbox_Finish, Key_Finish, Expansion_Finish} = fin_nxt;
    end
  end

  typedef struct {
    int load_cyc;
    int upds;
    int sk_bad;
    int swaps;
    int swap_at;
    int final_cyc;
    int done_cyc;
    int err_cyc;
    int err_round;
    int sel_at_err;
    int busy_bad;
    int err_at_load;
  } result_t;

  // Issue one Start pulse, then watch until Done, ERROR, or the cycle budget.
  task automatic run_block(input logic dec, output result_t r);
    r = '{-1, 0, 0, 0, -1, -1, -1, -1, -1, -1, 0, -1};
    @(negedge clk);
    Start = 1'b1;
    Decrypt = dec;
    @(posedge clk);
    #1;
    Start = 1'b0;
    Decrypt = ~dec;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (!Busy) r.busy_bad++;
      if (Load_Strobe && r.load_cyc < 0) begin
        r.load_cyc = c;
        r.err_at_load = int'(Error);
      end
      if (Round_Update) begin
        if (int'(Subkey_Index) != (dec ? 15 - r.upds : r.upds)) r.sk_bad++;
        if (Swap_Skip) begin
          r.swaps++;
          r.swap_at = r.upds;
        end
        r.upds++;
      end
      if (Final_Strobe) r.final_cyc = c;
      if (Done) begin
        r.done_cyc = c;
        break;
      end
      if (Error && Busy) begin
        r.err_cyc = c;
        r.err_round = int'(Round);
        r.sel_at_err = int'({Perm_Select, Sbox_Select, Key_Select, Expansion_Select});
        break;
      end
      if (!Busy) break;
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {14'd0, Busy, Done, Error, Load_Strobe, Expansion_Select, Key_Select,
            Sbox_Select, Perm_Select, Round_Update, Swap_Skip, Final_Strobe,
            Round, Subkey_Index, 1'b0};
  endfunction

  initial begin
    result_t r;
    int loads, dones, d1, d2, t;

    rst = 1'b1;
    Start = 1'b0;
    Decrypt = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", out_vec(), 32'd0);

    // Encrypt at minimum stage latency.
    run_block(1'b0, r);
    check("enc_load_cyc", r.load_cyc, 1);
    check("enc_updates", r.upds, 16);
    check("enc_subkeys", r.sk_bad, 0);
    check("enc_swap_count", r.swaps, 1);
    check("enc_swap_round", r.swap_at, 15);
    check("enc_final_cyc", r.final_cyc, 146);
    check("enc_done_cyc", r.done_cyc, 147);
    check("enc_busy_held", r.busy_bad, 0);
    @(negedge clk);
    check("enc_after_busy", {31'd0, Busy}, 32'd0);
    check("enc_after_done", {31'd0, Done}, 32'd0);

    // Decrypt: identical timing, reversed subkey order.
    run_block(1'b1, r);
    check("dec_load_cyc", r.load_cyc, 1);
    check("dec_subkeys", r.sk_bad, 0);
    check("dec_updates", r.upds, 16);
    check("dec_done_cyc", r.done_cyc, 147);

    // Slow S-box in round 7 stretches the block by 4 cycles.
    sbox_slow_round = 7;
    run_block(1'b0, r);
    sbox_slow_round = -1;
    check("slow_final_cyc", r.final_cyc, 150);
    check("slow_done_cyc", r.done_cyc, 151);
    check("slow_no_error", r.err_cyc, -1);

    // Perm never finishes in round 3: PERM entered at cycle 35, ERROR at 50.
    perm_hang_round = 3;
    run_block(1'b0, r);
    perm_hang_round = -1;
    check("to_err_cyc", r.err_cyc, 50);
    check("to_err_round", r.err_round, 3);
    check("to_err_selects", r.sel_at_err, 0);
    check("to_no_done", r.done_cyc, -1);
    @(negedge clk);
    check("to_idle_busy", {31'd0, Busy}, 32'd0);
    check("to_error_sticky", {31'd0, Error}, 32'd1);
    run_block(1'b0, r);
    check("to_error_cleared", r.err_at_load, 0);
    check("to_recover_done", r.done_cyc, 147);

    // Mid-block Start is ignored; rst aborts the block.
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    t = 0;
    while (int'(Round) != 10 && t < 300) begin @(negedge clk); t++; end
    check("mid_reach_r10", {31'd0, t < 300}, 32'd1);
    Start = 1'b1;
    loads = 0;
    repeat (2) begin @(negedge clk); if (Load_Strobe) loads++; end
    Start = 1'b0;
    t = 0;
    while (int'(Round) != 12 && t < 300) begin
      @(negedge clk);
      if (Load_Strobe) loads++;
      t++;
    end
    check("mid_start_ignored", loads, 0);
    check("mid_reach_r12", {31'd0, t < 300}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_outputs", out_vec(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (200) begin @(negedge clk); if (Done || Busy) dones++; end
    check("rst_no_done", dones, 0);

    // Start held high: consecutive blocks, Done pulses 148 cycles apart.
    @(negedge clk);
    Start = 1'b1;
    Decrypt = 1'b0;
    d1 = -1;
    d2 = -1;
    for (int c = 0; c < 400 && d2 < 0; c++) begin
      @(negedge clk);
      if (Done) begin
        if (d1 < 0) d1 = c; else d2 = c;
      end
    end
    Start = 1'b0;
    check("b2b_second_done", {31'd0, d2 >= 0}, 32'd1);
    check("b2b_spacing", d2 - d1, 148);
    t = 0;
    while (Busy && t < 300) begin @(negedge clk); t++; end
    check("b2b_settles", {31'd0, Busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
